id_ex_fwd_stage: RTL and testbench
==================================

Name: id_ex_fwd_stage

Overview:
- Parametrised ID/EX pipeline register with a generalised operand-forwarding network.
- Captures decoded instruction fields and NUM_SRC source operands, resolving each operand against NUM_FWD prioritised forwarding buses.
- Adds a valid bit, load-use hazard detection with bubble insertion, and refresh of held operands while stalled.
- Sits between the decoder/register file and the EX stage.

Parameters:
XLEN, 32, datapath width
NUM_SRC, 2, source operands per instruction
NUM_FWD, 2, forwarding buses; index 0 = EX (highest priority), ascending index = older stage
RA_W, 5, register address width
TYPE_W, 7, ins_type width
DET_W, 3, ins_details width

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global ready; low freezes the stage completely
clear  in  1  synchronous flush (branch mispredict)
stall_in  in  1  downstream stall; hold this stage
fwd_en  in  NUM_FWD  per-bus write-enable
fwd_addr  in  NUM_FWD*RA_W  per-bus destination register
fwd_data  in  NUM_FWD*XLEN  per-bus result
fwd0_is_load  in  1  bus 0 carries a load whose data is not yet available
in_valid  in  1  decode output valid
pc, imm  in  XLEN each  instruction pc / immediate
src_addr  in  NUM_SRC*RA_W  source register addresses
src_data  in  NUM_SRC*XLEN  register-file read data
rd_addr  in  RA_W  destination register
ins_type, ins_details, ins_diff  in  TYPE_W, DET_W, 1  decoded opcode fields
out_valid  out  1  registered valid
out_pc, out_imm  out  XLEN each  registered pc / immediate
out_src_data  out  NUM_SRC*XLEN  resolved operands
out_rd_addr, out_ins_type, out_ins_details, out_ins_diff  out  matching widths  registered fields
load_use_stall  out  1  combinational hold request to IF/ID

Behaviour:
- Reset is asynchronous. While rst_in is high, all outputs take NOP values: out_valid=0, out_ins_type=ALOPI, out_ins_details=ADDI, out_ins_diff=0, and every other output 0.
- Forward select (per operand i):
  - Choose the lowest j with fwd_en[j] && fwd_addr[j]==src_addr[i] && src_addr[i]!=0; otherwise use src_data[i].
  - Register 0 is never forwarded.
  - Each selected operand is fully overridden by the chosen bus; no partial merges.
- Hazard: hazard = in_valid && fwd_en[0] && fwd0_is_load && (some i with src_addr[i]!=0 && src_addr[i]==fwd_addr[0]). load_use_stall = hazard (combinational, no register).
- Clock-edge priority, highest first:
  1. clear: load NOP values.
  2. !rdy_in: hold every register unchanged; no refresh.
  3. stall_in: hold all fields. Refresh each held operand through the forward select, using its stored source address, so results retiring during the stall are not lost.
  4. hazard: insert a bubble (NOP values, out_valid=0). Upstream holds; the same instruction is re-captured once the load data reaches bus 1.
  5. Otherwise: capture all inputs with forward-resolved operands; out_valid=in_valid.
- Latency: 1 cycle from input to output.
- The stage stores NUM_SRC source addresses internally for refresh; they are cleared to 0 on reset and on clear.
- Simultaneous clear and stall_in: clear wins.
- Simultaneous stall_in and hazard: hold wins; load_use_stall is still asserted.
- Reset deasserted mid-stream: the first capture occurs on the next rising edge with rdy_in=1.

Decomposition:
- Shared package holds: ZeroWord, ALOPI, ADDI, and the NOP field bundle.
- One sub-module, fwd_select: combinational priority mux for one operand (parameters NUM_FWD, XLEN, RA_W).
  - NUM_SRC instances serve the capture path.
  - NUM_SRC instances serve the refresh path.

Test Plan:
- Reset: assert rst_in asynchronously mid-cycle -> outputs go to NOP immediately, out_valid=0, out_ins_type=ALOPI.
- Dual-match priority: src_addr[0]=5; bus0 writes x5=0x11, bus1 writes x5=0x22 -> out_src_data[0]=0x11 next cycle. Only bus1 matches -> 0x22.
- x0 guard: src_addr[1]=0, bus0 writes addr 0 with 0xDEAD -> out_src_data[1]=src_data[1].
- Load-use: bus0 is a load to x7 (fwd0_is_load=1), in_valid with src_addr[1]=7 -> load_use_stall=1 and the next output is a bubble. The following cycle bus1 carries x7=0x1234 -> the instruction is captured with 0x1234.
- Stall refresh: captured src x3=0xAAAA; stall_in held 3 cycles while bus1 writes x3=0xBBBB in cycle 2 -> out_src_data=0xBBBB and the other fields are unchanged.
- Freeze/flush: rdy_in=0 with active forwarding -> no change at all; then clear together with stall_in -> NOP on the next edge.

Source files
------------

// File: rtl/id_ex_fwd_stage_pkg.sv
// rtl/id_ex_fwd_stage_pkg.sv - shared constants and NOP field bundle for the ID/EX stage
package id_ex_fwd_stage_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [6:0]  ALOPI    = 7'b0010011;
  localparam logic [2:0]  ADDI     = 3'b000;

  // Decoded fields of the canonical NOP (addi x0, x0, 0)
  typedef struct packed {
    logic [6:0] ins_type;
    logic [2:0] ins_details;
    logic       ins_diff;
  } nop_fields_t;

  localparam nop_fields_t NopFields = '{ins_type: ALOPI, ins_details: ADDI, ins_diff: 1'b0};

endpackage

// File: rtl/id_ex_fwd_stage_fwd_select.sv
// rtl/id_ex_fwd_stage_fwd_select.sv - priority forwarding mux for one source operand
module fwd_select #(
  parameter int NUM_FWD = 2,
  parameter int XLEN    = 32,
  parameter int RA_W    = 5
) (
  input  logic [RA_W-1:0]         src_addr,
  input  logic [XLEN-1:0]         src_data,
  input  logic [NUM_FWD-1:0]      fwd_en,
  input  logic [NUM_FWD*RA_W-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]         data
);

  // Walk buses from oldest to youngest so the lowest matching index wins; x0 never forwards
  always_comb begin
    data = src_data;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (fwd_en[j] && (src_addr != '0) && (fwd_addr[j*RA_W +: RA_W] == src_addr)) begin
        data = fwd_data[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// rtl/id_ex_fwd_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubbles
module id_ex_fwd_stage
  import id_ex_fwd_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int RA_W    = 5,
  parameter int TYPE_W  = 7,
  parameter int DET_W   = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  input  logic                    stall_in,
  input  logic [NUM_FWD-1:0]      fwd_en,
  input  logic [NUM_FWD*RA_W-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    fwd0_is_load,
  input  logic                    in_valid,
  input  logic [XLEN-1:0]         pc,
  input  logic [XLEN-1:0]         imm,
  input  logic [NUM_SRC*RA_W-1:0] src_addr,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic [RA_W-1:0]         rd_addr,
  input  logic [TYPE_W-1:0]       ins_type,
  input  logic [DET_W-1:0]        ins_details,
  input  logic                    ins_diff,
  output logic                    out_valid,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_imm,
  output logic [NUM_SRC*XLEN-1:0] out_src_data,
  output logic [RA_W-1:0]         out_rd_addr,
  output logic [TYPE_W-1:0]       out_ins_type,
  output logic [DET_W-1:0]        out_ins_details,
  output logic                    out_ins_diff,
  output logic                    load_use_stall
);

  logic [NUM_SRC*RA_W-1:0] src_addr_q;
  logic [NUM_SRC*XLEN-1:0] cap_data;
  logic [NUM_SRC*XLEN-1:0] ref_data;
  logic                    hazard;
  logic                    src_hit;

  // Capture path resolves incoming operands; refresh path re-resolves held operands by stored address
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN), .RA_W(RA_W)) u_cap (
      .src_addr (src_addr[i*RA_W +: RA_W]),
      .src_data (src_data[i*XLEN +: XLEN]),
      .fwd_en   (fwd_en),
      .fwd_addr (fwd_addr),
      .fwd_data (fwd_data),
      .data     (cap_data[i*XLEN +: XLEN])
    );
    fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN), .RA_W(RA_W)) u_ref (
      .src_addr (src_addr_q[i*RA_W +: RA_W]),
      .src_data (out_src_data[i*XLEN +: XLEN]),
      .fwd_en   (fwd_en),
      .fwd_addr (fwd_addr),
      .fwd_data (fwd_data),
      .data     (ref_data[i*XLEN +: XLEN])
    );
  end

  // Load-use hazard: a non-x0 source needs the value an in-flight load on bus 0 has not produced yet
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((src_addr[i*RA_W +: RA_W] != '0) && (src_addr[i*RA_W +: RA_W] == fwd_addr[RA_W-1:0])) begin
        src_hit = 1'b1;
      end
    end
    hazard = in_valid && fwd_en[0] && fwd0_is_load && src_hit;
  end

  assign load_use_stall = hazard;

  // Pipeline register: clear > freeze > stall with refresh > bubble > capture
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid       <= 1'b0;
      out_pc          <= XLEN'(ZeroWord);
      out_imm         <= XLEN'(ZeroWord);
      out_src_data    <= '0;
      src_addr_q      <= '0;
      out_rd_addr     <= '0;
      out_ins_type    <= TYPE_W'(NopFields.ins_type);
      out_ins_details <= DET_W'(NopFields.ins_details);
      out_ins_diff    <= NopFields.ins_diff;
    end else if (clear || (rdy_in && !stall_in && hazard)) begin
      out_valid       <= 1'b0;
      out_pc          <= XLEN'(ZeroWord);
      out_imm         <= XLEN'(ZeroWord);
      out_src_data    <= '0;
      src_addr_q      <= '0;
      out_rd_addr     <= '0;
      out_ins_type    <= TYPE_W'(NopFields.ins_type);
      out_ins_details <= DET_W'(NopFields.ins_details);
      out_ins_diff    <= NopFields.ins_diff;
    end else if (!rdy_in) begin
      out_valid <= out_valid;
    end else if (stall_in) begin
      out_src_data <= ref_data;
    end else begin
      out_valid       <= in_valid;
      out_pc          <= pc;
      out_imm         <= imm;
      out_src_data    <= cap_data;
      src_addr_q      <= src_addr;
      out_rd_addr     <= rd_addr;
      out_ins_type    <= ins_type;
      out_ins_details <= ins_details;
      out_ins_diff    <= ins_diff;
    end
  end

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// tb/tb_id_ex_fwd_stage.sv - scoreboard bench for the ID/EX forwarding stage
module tb_id_ex_fwd_stage;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        stall_in = 1'b0;
  logic [1:0]  fwd_en = '0;
  logic [9:0]  fwd_addr = '0;
  logic [63:0] fwd_data = '0;
  logic        fwd0_is_load = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [9:0]  src_addr = '0;
  logic [63:0] src_data = '0;
  logic [4:0]  rd_addr = '0;
  logic [6:0]  ins_type = '0;
  logic [2:0]  ins_details = '0;
  logic        ins_diff = 1'b0;

  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [63:0] out_src_data;
  logic [4:0]  out_rd_addr;
  logic [6:0]  out_ins_type;
  logic [2:0]  out_ins_details;
  logic        out_ins_diff;
  logic        load_use_stall;

  id_ex_fwd_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .stall_in(stall_in),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd0_is_load(fwd0_is_load),
    .in_valid(in_valid), .pc(pc), .imm(imm), .src_addr(src_addr), .src_data(src_data),
    .rd_addr(rd_addr), .ins_type(ins_type), .ins_details(ins_details), .ins_diff(ins_diff),
    .out_valid(out_valid), .out_pc(out_pc), .out_imm(out_imm), .out_src_data(out_src_data),
    .out_rd_addr(out_rd_addr), .out_ins_type(out_ins_type), .out_ins_details(out_ins_details),
    .out_ins_diff(out_ins_diff), .load_use_stall(load_use_stall)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [4:0]  rd;
    logic [6:0]  ty;
    logic [2:0]  det;
    logic        diff;
    logic        lus;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t nop_exp(string n, logic lus);
    exp_t r;
    r.name = n; r.valid = 1'b0; r.pc = '0; r.imm = '0; r.s0 = '0; r.s1 = '0;
    r.rd = '0; r.ty = 7'h13; r.det = 3'h0; r.diff = 1'b0; r.lus = lus;
    return r;
  endfunction

  function automatic exp_t ins_exp(string n, logic v, logic [31:0] p, logic [31:0] im,
                                   logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                                   logic [6:0] ty, logic [2:0] det, logic df, logic lus);
    exp_t r;
    r.name = n; r.valid = v; r.pc = p; r.imm = im; r.s0 = a; r.s1 = b;
    r.rd = rd; r.ty = ty; r.det = det; r.diff = df; r.lus = lus;
    return r;
  endfunction

  task automatic cmp(string tag, string f, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, f, act, expv);
    end
  endtask

  // Monitor: sample one cycle's outputs 1ns after each rising edge when a record is pending
  initial begin
    exp_t m;
    forever begin
      @(posedge clk_in);
      #1;
      if (q.size() > 0) begin
        m = q.pop_front();
        cmp(m.name, "valid", 32'(out_valid), 32'(m.valid));
        cmp(m.name, "pc", out_pc, m.pc);
        cmp(m.name, "imm", out_imm, m.imm);
        cmp(m.name, "src0", out_src_data[31:0], m.s0);
        cmp(m.name, "src1", out_src_data[63:32], m.s1);
        cmp(m.name, "rd", 32'(out_rd_addr), 32'(m.rd));
        cmp(m.name, "type", 32'(out_ins_type), 32'(m.ty));
        cmp(m.name, "details", 32'(out_ins_details), 32'(m.det));
        cmp(m.name, "diff", 32'(out_ins_diff), 32'(m.diff));
        cmp(m.name, "load_use_stall", 32'(load_use_stall), 32'(m.lus));
      end
    end
  end

  task automatic set_ins(logic v, logic [31:0] p, logic [31:0] im, logic [4:0] a0, logic [31:0] d0,
                         logic [4:0] a1, logic [31:0] d1, logic [4:0] rd, logic [6:0] ty,
                         logic [2:0] det, logic df);
    in_valid = v; pc = p; imm = im; src_addr = {a1, a0}; src_data = {d1, d0};
    rd_addr = rd; ins_type = ty; ins_details = det; ins_diff = df;
  endtask

  task automatic set_fwd(logic [1:0] en, logic [4:0] a0, logic [31:0] d0, logic [4:0] a1,
                         logic [31:0] d1, logic ld);
    fwd_en = en; fwd_addr = {a1, a0}; fwd_data = {d1, d0}; fwd0_is_load = ld;
  endtask

  initial begin
    int waited;
    // Reset held from time 0
    @(negedge clk_in);
    q.push_back(nop_exp("reset", 1'b0));
    @(negedge clk_in);
    rst_in = 1'b0;

    // Both buses hit x5: bus 0 wins
    set_ins(1'b1, 32'h100, 32'h4, 5'd5, 32'h55, 5'd6, 32'h66, 5'd9, 7'h33, 3'h1, 1'b1);
    set_fwd(2'b11, 5'd5, 32'h11, 5'd5, 32'h22, 1'b0);
    q.push_back(ins_exp("dual_match", 1'b1, 32'h100, 32'h4, 32'h11, 32'h66, 5'd9, 7'h33, 3'h1, 1'b1, 1'b0));

    @(negedge clk_in);
    pc = 32'h104;
    set_fwd(2'b10, 5'd5, 32'h11, 5'd5, 32'h22, 1'b0);
    q.push_back(ins_exp("bus1_only", 1'b1, 32'h104, 32'h4, 32'h22, 32'h66, 5'd9, 7'h33, 3'h1, 1'b1, 1'b0));

    @(negedge clk_in);
    set_ins(1'b1, 32'h108, 32'h8, 5'd6, 32'h60, 5'd0, 32'h77, 5'd9, 7'h33, 3'h0, 1'b0);
    set_fwd(2'b01, 5'd0, 32'hDEAD, 5'd0, 32'h0, 1'b0);
    q.push_back(ins_exp("x0_guard", 1'b1, 32'h108, 32'h8, 32'h60, 32'h77, 5'd9, 7'h33, 3'h0, 1'b0, 1'b0));

    // Load on bus 0 to x7, consumer reads x7: bubble then capture with bus 1 data
    @(negedge clk_in);
    set_ins(1'b1, 32'h200, 32'h8, 5'd2, 32'h20, 5'd7, 32'h70, 5'd10, 7'h03, 3'h2, 1'b0);
    set_fwd(2'b01, 5'd7, 32'hBAD0, 5'd0, 32'h0, 1'b1);
    q.push_back(nop_exp("load_use_bubble", 1'b1));

    @(negedge clk_in);
    set_fwd(2'b10, 5'd0, 32'h0, 5'd7, 32'h1234, 1'b0);
    q.push_back(ins_exp("load_use_recapture", 1'b1, 32'h200, 32'h8, 32'h20, 32'h1234, 5'd10, 7'h03, 3'h2, 1'b0, 1'b0));

    // Capture x3=AAAA then stall three cycles with x3 retiring on bus 1 in the second
    @(negedge clk_in);
    set_ins(1'b1, 32'h300, 32'hC, 5'd3, 32'hAAAA, 5'd4, 32'h40, 5'd11, 7'h33, 3'h0, 1'b0);
    set_fwd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    q.push_back(ins_exp("stall_capture", 1'b1, 32'h300, 32'hC, 32'hAAAA, 32'h40, 5'd11, 7'h33, 3'h0, 1'b0, 1'b0));

    @(negedge clk_in);
    stall_in = 1'b1;
    set_ins(1'b1, 32'h999, 32'h1, 5'd3, 32'h1, 5'd9, 32'h2, 5'd12, 7'h13, 3'h7, 1'b1);
    q.push_back(ins_exp("stall_hold1", 1'b1, 32'h300, 32'hC, 32'hAAAA, 32'h40, 5'd11, 7'h33, 3'h0, 1'b0, 1'b0));

    @(negedge clk_in);
    set_fwd(2'b10, 5'd0, 32'h0, 5'd3, 32'hBBBB, 1'b0);
    q.push_back(ins_exp("stall_refresh", 1'b1, 32'h300, 32'hC, 32'hBBBB, 32'h40, 5'd11, 7'h33, 3'h0, 1'b0, 1'b0));

    // Hazard during stall: hold wins but the hold request is still raised
    @(negedge clk_in);
    set_ins(1'b1, 32'h999, 32'h1, 5'd8, 32'h1, 5'd9, 32'h2, 5'd12, 7'h13, 3'h7, 1'b1);
    set_fwd(2'b01, 5'd8, 32'h8888, 5'd0, 32'h0, 1'b1);
    q.push_back(ins_exp("stall_hazard", 1'b1, 32'h300, 32'hC, 32'hBBBB, 32'h40, 5'd11, 7'h33, 3'h0, 1'b0, 1'b1));

    // Freeze with active forwarding on both stored addresses
    @(negedge clk_in);
    stall_in = 1'b0; rdy_in = 1'b0;
    set_ins(1'b1, 32'h500, 32'h2, 5'd3, 32'h5, 5'd4, 32'h6, 5'd1, 7'h63, 3'h4, 1'b1);
    set_fwd(2'b11, 5'd3, 32'hCCCC, 5'd4, 32'hDDDD, 1'b0);
    q.push_back(ins_exp("freeze", 1'b1, 32'h300, 32'hC, 32'hBBBB, 32'h40, 5'd11, 7'h33, 3'h0, 1'b0, 1'b0));

    @(negedge clk_in);
    rdy_in = 1'b1; clear = 1'b1; stall_in = 1'b1;
    q.push_back(nop_exp("clear_and_stall", 1'b0));

    @(negedge clk_in);
    clear = 1'b0; stall_in = 1'b0;
    set_ins(1'b1, 32'h600, 32'h10, 5'd1, 32'h101, 5'd2, 32'h202, 5'd13, 7'h63, 3'h5, 1'b1);
    set_fwd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    q.push_back(ins_exp("capture", 1'b1, 32'h600, 32'h10, 32'h101, 32'h202, 5'd13, 7'h63, 3'h5, 1'b1, 1'b0));

    // Short reset pulse between edges while frozen: only an asynchronous reset clears the outputs
    @(negedge clk_in);
    rdy_in = 1'b0;
    q.push_back(nop_exp("async_reset", 1'b0));
    #1 rst_in = 1'b1;
    #2 rst_in = 1'b0;

    @(negedge clk_in);
    rdy_in = 1'b1;
    pc = 32'h604;
    q.push_back(ins_exp("post_reset_capture", 1'b1, 32'h604, 32'h10, 32'h101, 32'h202, 5'd13, 7'h63, 3'h5, 1'b1, 1'b0));

    @(negedge clk_in);
    set_ins(1'b0, 32'h700, 32'h14, 5'd9, 32'h909, 5'd10, 32'hA0A, 5'd14, 7'h33, 3'h6, 1'b0);
    q.push_back(ins_exp("invalid_capture", 1'b0, 32'h700, 32'h14, 32'h909, 32'hA0A, 5'd14, 7'h33, 3'h6, 1'b0, 1'b0));

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk_in);
      waited++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d records left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
